// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush control with multi-cycle op wait FSM.
// Optional HAZARD_CTRL_STATS_EN adds saturating stall/flush event counters.
module hazard_controller #(
  parameter int unsigned MC_MAX_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_rd,
  input  logic       ex_mc_start,
  input  logic       mc_done,
  input  logic       ex_branch_taken,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idex_stall,
  output logic       idex_flush,
  output logic       exmem_bubble,
  output logic       mc_busy,
  output logic       mc_timeout
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);
  localparam logic [7:0] MC_MAX = 8'(MC_MAX_CYCLES);
  typedef enum logic {RUN, MC_WAIT} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic run, br, mcs, lu, load_use, timeout, wait_stall;
  assign run = state_q == RUN;
  assign load_use = ex_mem_rd && ex_rd != 5'd0 &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  assign br = run && ex_branch_taken;
  assign mcs = run && !br && ex_mc_start && !mc_done;
  assign lu = run && !br && !mcs && load_use;
  assign timeout = !run && !mc_done && cnt_q == MC_MAX;
  assign wait_stall = !run && !mc_done && !timeout;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (run) begin
      if (mcs) begin
        state_d = MC_WAIT;
        cnt_d = 8'd1;
      end
    end else if (mc_done || timeout) begin
      state_d = RUN;
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end
  // Every output is gated by rst_n so it reads 0 while reset is held, whatever the inputs.
  always_comb begin
    pc_stall = rst_n && (mcs || lu || wait_stall);
    ifid_stall = rst_n && (mcs || lu || wait_stall);
    ifid_flush = rst_n && br;
    idex_stall = rst_n && (mcs || wait_stall);
    idex_flush = rst_n && (br || lu);
    exmem_bubble = rst_n && (mcs || wait_stall);
    mc_busy = rst_n && !run;
    mc_timeout = rst_n && timeout;
  end
`ifdef HAZARD_CTRL_STATS_EN
  logic [31:0] stall_q, flush_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (pc_stall && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (ifid_flush && flush_q != '1) flush_q <= flush_q + 32'd1;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: table-driven and sequence checks of hazard_controller.
module tb_hazard_controller;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_rd, ex_mc_start, mc_done, ex_branch_taken;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble, mc_busy, mc_timeout;
  logic [7:0] outs;
  int total = 0;
  int bad = 0;
`ifdef HAZARD_CTRL_STATS_EN
  logic [31:0] stall_cycles, flush_events;
`endif
  always #5 clk = ~clk;
  hazard_controller #(.MC_MAX_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_rd(ex_mem_rd), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
    .ex_branch_taken(ex_branch_taken),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_bubble(exmem_bubble),
    .mc_busy(mc_busy), .mc_timeout(mc_timeout)
`ifdef HAZARD_CTRL_STATS_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );
  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble, mc_busy, mc_timeout}
  assign outs = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble, mc_busy, mc_timeout};
  localparam logic [7:0] IDLE = 8'b0000_0000;
  localparam logic [7:0] LU = 8'b1100_1000;
  localparam logic [7:0] BR = 8'b0010_1000;
  localparam logic [7:0] MCS = 8'b1101_0100;
  localparam logic [7:0] WAIT = 8'b1101_0110;
  localparam logic [7:0] DONE = 8'b0000_0010;
  localparam logic [7:0] TMO = 8'b0000_0011;
  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic u1;
    logic u2;
    logic [4:0] rd;
    logic mr;
    logic mcs;
    logic dn;
    logic br;
    logic [7:0] exp;
    string name;
  } vec_t;
  vec_t v [11];
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask
  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic a, input logic b,
                       input logic [4:0] rd, input logic mr, input logic mcs, input logic dn, input logic br);
    @(negedge clk);
    id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = a; id_uses_rs2 = b;
    ex_rd = rd; ex_mem_rd = mr; ex_mc_start = mcs; mc_done = dn; ex_branch_taken = br;
    #1;
  endtask
  initial begin
    v[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, "idle"};
    v[1]  = '{5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU, "lu_rs2"};
    v[2]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU, "lu_rs1"};
    v[3]  = '{5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, "rs1_unused"};
    v[4]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, "x0_load"};
    v[5]  = '{5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, "not_load"};
    v[6]  = '{5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, BR, "br_over_lu"};
    v[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, BR, "br_over_mc"};
    v[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, IDLE, "mc_same_done"};
    v[9]  = '{5'd9, 5'd3, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, LU, "mc_done_lu"};
    v[10] = '{5'd3, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, "no_match"};
    rst_n = 1'b0;
    drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("reset_outs", outs, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(v[i].rs1, v[i].rs2, v[i].u1, v[i].u2, v[i].rd, v[i].mr, v[i].mcs, v[i].dn, v[i].br);
      chk(v[i].name, outs, v[i].exp);
    end
    drive(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_cycle", outs, LU);
    drive(5'd1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_after", outs, IDLE);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mc_start", outs, MCS);
    for (int i = 0; i < 4; i++) begin
      drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
      chk($sformatf("mc_wait%0d", i), outs, WAIT);
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mc_done", outs, DONE);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mc_back_run", outs, IDLE);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("tmo_start", outs, MCS);
    for (int i = 1; i < 8; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("tmo_wait%0d", i), outs, WAIT);
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tmo_pulse", outs, TMO);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tmo_back_run", outs, IDLE);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_mc_start", outs, MCS);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mc_wait", outs, WAIT);
    @(negedge clk);
    rst_n = 1'b0;
    ex_branch_taken = 1'b1;
    #1;
    chk("rst_mid_wait", outs, IDLE);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rst_released", outs, IDLE);
`ifdef HAZARD_CTRL_STATS_EN
    chk("stall_cnt_rst", stall_cycles[7:0] | stall_cycles[31:24], 8'd0);
    chk("flush_cnt_rst", flush_events[7:0] | flush_events[31:24], 8'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
